// File: rtl/jk_seq_ctrl.sv
// jk_seq_ctrl: up/down counter sequencer driving a W-bit register of JK cells.
// Loads a start value on start, steps once per clock until q matches term,
// then emits a one-cycle done pulse and returns to idle.
// Optional build macro: JK_SEQ_AUTO_RELOAD_EN (reload on terminal count,
// exit only via stop).
module jk_seq_ctrl #(
   parameter int unsigned W = 4
) (
   input  logic         c,
   input  logic         rst,
   input  logic         start,
   input  logic         stop,
   input  logic         dir,
   input  logic         hold,
   input  logic [W-1:0] ld_val,
   input  logic [W-1:0] term,
   output logic [W-1:0] q,
   output logic         busy,
   output logic         tc,
   output logic         done
);

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      COUNT = 2'b01,
      DONE  = 2'b10
   } state_t;

   state_t         state_q, state_d;
   logic [W-1:0]   q_q, q_d;
   logic           done_q, done_d;
   logic [W-1:0]   j, k;
   logic [W-1:0]   t;

   assign q    = q_q;
   assign busy = (state_q == COUNT);
   assign tc   = (state_q == COUNT) && (q_q == term);
   assign done = done_q;

   // Toggle enables: bit i flips when all lower bits are 1 (up) or 0 (down).
   always_comb begin
      t    = '0;
      t[0] = 1'b1;
      for (int unsigned i = 1; i < W; i++) begin
         t[i] = t[i-1] & (dir ? q_q[i-1] : ~q_q[i-1]);
      end
   end

   // Next state, JK controls and done pulse; priority in COUNT is stop > tc > hold > step.
   always_comb begin
      state_d = state_q;
      j       = '0;
      k       = '0;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               j       = ld_val;
               k       = ~ld_val;
               state_d = COUNT;
            end
         end
         COUNT: begin
            if (stop) begin
               state_d = DONE;
               done_d  = 1'b1;
            end else if (tc) begin
               done_d = 1'b1;
`ifdef JK_SEQ_AUTO_RELOAD_EN
               j      = ld_val;
               k      = ~ld_val;
`else
               state_d = DONE;
`endif
            end else if (!hold) begin
               j = t;
               k = t;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // JK cell characteristic equation: q+ = j&~q | ~k&q.
   always_comb begin
      q_d = (j & ~q_q) | (~k & q_q);
   end

   // State, counter cells and done flop with asynchronous reset.
   always_ff @(posedge c or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         q_q     <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         q_q     <= q_d;
         done_q  <= done_d;
      end
   end

endmodule

// File: tb/tb_jk_seq_ctrl.sv
// Directed testbench for jk_seq_ctrl (W=4), hand-computed expectations.
module tb_jk_seq_ctrl;

   localparam int unsigned W = 4;

   logic         c;
   logic         rst;
   logic         start;
   logic         stop;
   logic         dir;
   logic         hold;
   logic [W-1:0] ld_val;
   logic [W-1:0] term;
   logic [W-1:0] q;
   logic         busy;
   logic         tc;
   logic         done;

   int checks = 0;
   int errors = 0;

   jk_seq_ctrl #(.W(W)) dut (
      .c      (c),
      .rst    (rst),
      .start  (start),
      .stop   (stop),
      .dir    (dir),
      .hold   (hold),
      .ld_val (ld_val),
      .term   (term),
      .q      (q),
      .busy   (busy),
      .tc     (tc),
      .done   (done)
   );

   initial c = 1'b0;
   always #5 c = ~c;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge c);
      #1;
   endtask

   // q, busy, tc, done together
   task automatic chk_all(input string tag, input int eq, input int eb, input int et, input int ed);
      check({tag, ".q"},    32'(q),    32'(eq));
      check({tag, ".busy"}, 32'(busy), 32'(eb));
      check({tag, ".tc"},   32'(tc),   32'(et));
      check({tag, ".done"}, 32'(done), 32'(ed));
   endtask

   initial begin
      rst = 1'b0; start = 1'b0; stop = 1'b0; dir = 1'b1; hold = 1'b0;
      ld_val = '0; term = '0;

      // 1: mid-clock reset, then up run 3..6
      tick();
      tick();
      #2 rst = 1'b1;
      #1 chk_all("t1_rst", 0, 0, 0, 0);
      #1 rst = 1'b0;
      tick();
      chk_all("t1_idle", 0, 0, 0, 0);
      ld_val = 4'd3; term = 4'd6; dir = 1'b1; start = 1'b1;
      tick(); start = 1'b0; ld_val = 4'd9;
      chk_all("t1_q3", 3, 1, 0, 0);
      tick(); chk_all("t1_q4", 4, 1, 0, 0);
      tick(); chk_all("t1_q5", 5, 1, 0, 0);
      tick(); chk_all("t1_q6", 6, 1, 1, 0);
      tick(); chk_all("t1_done", 6, 0, 0, 1);
      tick(); chk_all("t1_idle2", 6, 0, 0, 0);

      // 2: down run with wrap 1,0,15,14
      ld_val = 4'd1; term = 4'd14; dir = 1'b0; start = 1'b1;
      tick(); start = 1'b0;
      chk_all("t2_q1", 1, 1, 0, 0);
      tick(); chk_all("t2_q0", 0, 1, 0, 0);
      tick(); chk_all("t2_q15", 15, 1, 0, 0);
      tick(); chk_all("t2_q14", 14, 1, 1, 0);
      tick(); chk_all("t2_done", 14, 0, 0, 1);
      tick(); chk_all("t2_idle", 14, 0, 0, 0);

      // 3: hold, stop, start ignored while busy/DONE
      ld_val = 4'd0; term = 4'd9; dir = 1'b1; start = 1'b1;
      tick(); start = 1'b0;
      chk_all("t3_q0", 0, 1, 0, 0);
      tick(); chk_all("t3_q1", 1, 1, 0, 0);
      tick(); chk_all("t3_q2", 2, 1, 0, 0);
      hold = 1'b1; start = 1'b1; ld_val = 4'd12;
      tick(); chk_all("t3_hold1", 2, 1, 0, 0);
      tick(); chk_all("t3_hold2", 2, 1, 0, 0);
      hold = 1'b0; start = 1'b0;
      tick(); chk_all("t3_q3", 3, 1, 0, 0);
      tick(); chk_all("t3_q4", 4, 1, 0, 0);
      tick(); chk_all("t3_q5", 5, 1, 0, 0);
      stop = 1'b1;
      tick(); chk_all("t3_done", 5, 0, 0, 1);
      stop = 1'b0; start = 1'b1;
      tick(); chk_all("t3_idle", 5, 0, 0, 0);
      start = 1'b0;
      tick(); chk_all("t3_idle2", 5, 0, 0, 0);

      // 4a: ld_val == term
      ld_val = 4'd7; term = 4'd7; dir = 1'b1; start = 1'b1;
      tick(); start = 1'b0;
      chk_all("t4_eq", 7, 1, 1, 0);
      tick(); chk_all("t4_eq_done", 7, 0, 0, 1);
      tick(); chk_all("t4_eq_idle", 7, 0, 0, 0);

      // 4b: reset mid-run at q=4
      ld_val = 4'd0; term = 4'd9; start = 1'b1;
      tick(); start = 1'b0;
      tick(); tick(); tick(); tick();
      chk_all("t4_q4", 4, 1, 0, 0);
      #2 rst = 1'b1;
      #1 chk_all("t4_rst", 0, 0, 0, 0);
      tick(); rst = 1'b0;
      chk_all("t4_rst_hold", 0, 0, 0, 0);
      tick(); chk_all("t4_nodone", 0, 0, 0, 0);

      // up wrap 14,15,0,1 with term moved mid-run
      ld_val = 4'd14; term = 4'd5; dir = 1'b1; start = 1'b1;
      tick(); start = 1'b0;
      chk_all("tw_q14", 14, 1, 0, 0);
      tick(); chk_all("tw_q15", 15, 1, 0, 0);
      term = 4'd1;
      tick(); chk_all("tw_q0", 0, 1, 0, 0);
      tick(); chk_all("tw_q1", 1, 1, 1, 0);

`ifdef JK_SEQ_AUTO_RELOAD_EN
      tick(); chk_all("tw_reload", 14, 1, 0, 1);
      stop = 1'b1;
      tick(); chk_all("tw_stop", 14, 0, 0, 1);
      stop = 1'b0;
      tick(); chk_all("tw_idle", 14, 0, 0, 0);

      // 5: auto reload 2,3,4,2,3,4
      ld_val = 4'd2; term = 4'd4; dir = 1'b1; start = 1'b1;
      tick(); start = 1'b0;
      chk_all("t5_q2", 2, 1, 0, 0);
      tick(); chk_all("t5_q3", 3, 1, 0, 0);
      tick(); chk_all("t5_q4", 4, 1, 1, 0);
      tick(); chk_all("t5_r2", 2, 1, 0, 1);
      tick(); chk_all("t5_r3", 3, 1, 0, 0);
      tick(); chk_all("t5_r4", 4, 1, 1, 0);
      tick(); chk_all("t5_rr2", 2, 1, 0, 1);
      stop = 1'b1;
      tick(); chk_all("t5_stop", 2, 0, 0, 1);
      stop = 1'b0;
      tick(); chk_all("t5_idle", 2, 0, 0, 0);
`else
      tick(); chk_all("tw_done", 1, 0, 0, 1);
      tick(); chk_all("tw_idle", 1, 0, 0, 0);
`endif

      // 6: start held high, back-to-back runs
      ld_val = 4'd5; term = 4'd6; dir = 1'b1; start = 1'b1;
      tick(); chk_all("t6_a5", 5, 1, 0, 0);
      tick(); chk_all("t6_a6", 6, 1, 1, 0);
`ifdef JK_SEQ_AUTO_RELOAD_EN
      tick(); chk_all("t6_rl", 5, 1, 0, 1);
      stop = 1'b1;
      tick(); chk_all("t6_stop", 5, 0, 0, 1);
      stop = 1'b0;
      tick(); chk_all("t6_gap", 5, 0, 0, 0);
      tick(); chk_all("t6_b5", 5, 1, 0, 0);
`else
      tick(); chk_all("t6_adone", 6, 0, 0, 1);
      tick(); chk_all("t6_gap", 6, 0, 0, 0);
      tick(); chk_all("t6_b5", 5, 1, 0, 0);
      tick(); chk_all("t6_b6", 6, 1, 1, 0);
      tick(); chk_all("t6_bdone", 6, 0, 0, 1);
`endif
      start = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
